// File: rtl/mem_access_unit_pkg.sv
// ---------------------------------------------------------------------------
// mem_access_unit_pkg
//
// Purpose : shared definitions for the MEM-stage load/store responder.
//           Holds the access-type codes (the decoder emits the same codes),
//           the responder FSM state encoding, and the legality check used to
//           decide whether a request may reach the memory port at all.
//
// Contents:
//   access_type_e  - 3-bit access-type code carried from decode to MEM
//   mau_state_e    - responder FSM states
//   accessLegal()  - 1 when a (write, type, addr[1:0]) triple may be issued
// ---------------------------------------------------------------------------
package mem_access_unit_pkg;

   // Access-type codes. Bit 2 selects byte, bit 1 selects half, and bit 0
   // marks the sign-extending variant of a load.
   typedef enum logic [2:0] {
      DT_WORD  = 3'b000,
      DT_HALFU = 3'b010,
      DT_HALF  = 3'b011,
      DT_BYTEU = 3'b100,
      DT_BYTE  = 3'b101
   } access_type_e;

   // Responder FSM states.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } mau_state_e;

   // A request is legal when its type is one of the five known codes, the
   // address is naturally aligned for its size, and a store never uses one
   // of the sign-extending codes (they only mean something for loads).
   function automatic logic accessLegal(input logic       isWrite,
                                        input logic [2:0] accType,
                                        input logic [1:0] addrLo);
      logic legal;
      legal = 1'b0;
      case (accType)
         DT_WORD:  legal = (addrLo == 2'b00);
         DT_HALFU: legal = (addrLo[0] == 1'b0);
         DT_HALF:  legal = (addrLo[0] == 1'b0) && !isWrite;
         DT_BYTEU: legal = 1'b1;
         DT_BYTE:  legal = !isWrite;
         default:  legal = 1'b0;
      endcase
      return legal;
   endfunction

endpackage

// File: rtl/mem_access_unit_load_ext.sv
// ---------------------------------------------------------------------------
// mem_load_ext
//
// Purpose : purely combinational load-data aligner/extender. Picks the byte
//           or half-word lane out of a little-endian memory word and sign- or
//           zero-extends it according to the access type. Kept standalone so
//           the instruction-set simulator model can reuse the same logic.
//
// Ports   :
//   i_rdata [31:0]  raw word returned by the data memory
//   i_addr  [1:0]   low bits of the byte address (lane select)
//   i_type  [2:0]   access-type code
//   o_data  [31:0]  extended load result
// ---------------------------------------------------------------------------
module mem_load_ext
   import mem_access_unit_pkg::*;
(
   input  logic [31:0] i_rdata,
   input  logic [1:0]  i_addr,
   input  logic [2:0]  i_type,
   output logic [31:0] o_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // Lane selection: byte lane is addr[1:0], half lane is addr[1]
   // (little-endian, so lane 0 sits in the least significant bits).
   always_comb begin
      w_byte = 8'h00;
      case (i_addr)
         2'b00: w_byte = i_rdata[7:0];
         2'b01: w_byte = i_rdata[15:8];
         2'b10: w_byte = i_rdata[23:16];
         2'b11: w_byte = i_rdata[31:24];
         default: w_byte = 8'h00;
      endcase
      w_half = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];
   end

   // Extension: the signed codes replicate the lane's top bit, the unsigned
   // codes pad with zeros, and a word passes straight through.
   always_comb begin
      o_data = i_rdata;
      case (i_type)
         DT_BYTE:  o_data = {{24{w_byte[7]}}, w_byte};
         DT_BYTEU: o_data = {24'h000000, w_byte};
         DT_HALF:  o_data = {{16{w_half[15]}}, w_half};
         DT_HALFU: o_data = {16'h0000, w_half};
         default:  o_data = i_rdata;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
//
// Purpose : MEM-stage load/store responder. Converts each legal load or
//           store held in the MEM pipeline register into exactly one
//           transaction on a word-wide, variable-latency data-memory port,
//           stalls the pipeline while that transaction is in flight, and
//           returns the extended load data. Illegal accesses (bad type,
//           misaligned, or a signed code on a store) raise a one-cycle
//           addr_err and never touch memory.
//
// Ports   :
//   clk, rst_n          clock, synchronous active-low reset
//   req_valid           MEM stage holds a load/store
//   req_write           1 = store, 0 = load
//   req_type [2:0]      access-type code
//   req_addr [31:0]     effective byte address
//   req_wdata[31:0]     store data, low-aligned
//   stall               hold the MEM stage
//   resp_valid          one-cycle pulse, resp_rdata valid (loads)
//   resp_rdata[31:0]    extended load result, held until the next load
//   addr_err            one-cycle pulse for an illegal access
//   mem_req/mem_we      memory request / write strobe
//   mem_addr[31:0]      word-aligned address
//   mem_be[3:0]         byte enables
//   mem_wdata[31:0]     lane-replicated store data
//   mem_gnt             request accepted
//   mem_rvalid          read data valid
//   mem_rdata[31:0]     read word
// ---------------------------------------------------------------------------
module mem_access_unit
   import mem_access_unit_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   input  logic        req_write,
   input  logic [2:0]  req_type,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        stall,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        addr_err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata
);

   mau_state_e  r_state;
   logic        r_write;
   logic [2:0]  r_type;
   logic [1:0]  r_addrLo;
   logic        r_respValid;
   logic [31:0] r_respRdata;
   logic        r_memReq;
   logic        r_memWe;
   logic [31:0] r_memAddr;
   logic [3:0]  r_memBe;
   logic [31:0] r_memWdata;

   logic        w_legal;
   logic        w_accept;
   logic        w_reject;
   logic [3:0]  w_be;
   logic [31:0] w_wdata;
   logic [31:0] w_loadData;

   // Request qualification. Only IDLE looks at the pipeline register, so a
   // request held stable during REQ/WAIT/DONE is never issued twice.
   always_comb begin
      w_legal  = accessLegal(req_write, req_type, req_addr[1:0]);
      w_accept = (r_state == IDLE) && req_valid && w_legal;
      w_reject = (r_state == IDLE) && req_valid && !w_legal;
   end

   // Byte enables and store-lane replication are computed from the live
   // request and registered at acceptance, which keeps them stable for as
   // long as mem_req is waiting on a grant. Replicating the store data means
   // the memory only has to honour mem_be, not shift the data itself.
   always_comb begin
      w_be    = 4'b0000;
      w_wdata = req_wdata;
      case (req_type)
         DT_WORD: begin
            w_be    = 4'b1111;
            w_wdata = req_wdata;
         end
         DT_HALFU, DT_HALF: begin
            w_be    = req_addr[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{req_wdata[15:0]}};
         end
         DT_BYTEU, DT_BYTE: begin
            w_be    = 4'b0001 << req_addr[1:0];
            w_wdata = {4{req_wdata[7:0]}};
         end
         default: begin
            w_be    = 4'b0000;
            w_wdata = req_wdata;
         end
      endcase
   end

   // Load data is extended from the latched type/lane, not the live request,
   // since the pipeline inputs only have to be stable, not re-decoded.
   mem_load_ext u_load_ext (
      .i_rdata (mem_rdata),
      .i_addr  (r_addrLo),
      .i_type  (r_type),
      .o_data  (w_loadData)
   );

   // Responder FSM. All memory-side outputs and the response are registered
   // here; mem_req therefore first rises the cycle after acceptance. A reset
   // in any state drops the transaction with no response, and because
   // mem_rvalid is only looked at in WAIT a late read return is harmless.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_write     <= 1'b0;
         r_type      <= 3'b000;
         r_addrLo    <= 2'b00;
         r_respValid <= 1'b0;
         r_respRdata <= 32'h0000_0000;
         r_memReq    <= 1'b0;
         r_memWe     <= 1'b0;
         r_memAddr   <= 32'h0000_0000;
         r_memBe     <= 4'b0000;
         r_memWdata  <= 32'h0000_0000;
      end else begin
         r_respValid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_write    <= req_write;
                  r_type     <= req_type;
                  r_addrLo   <= req_addr[1:0];
                  r_memReq   <= 1'b1;
                  r_memWe    <= req_write;
                  r_memAddr  <= {req_addr[31:2], 2'b00};
                  r_memBe    <= w_be;
                  r_memWdata <= w_wdata;
                  r_state    <= REQ;
               end
            end
            REQ: begin
               if (mem_gnt) begin
                  r_memReq <= 1'b0;
                  r_state  <= r_write ? DONE : WAIT;
               end
            end
            WAIT: begin
               if (mem_rvalid) begin
                  r_respRdata <= w_loadData;
                  r_respValid <= 1'b1;
                  r_state     <= DONE;
               end
            end
            DONE: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   // Stall must cover the acceptance cycle itself, so it is combinational.
   // DONE is deliberately unstalled: the pipeline advances at its end.
   assign stall      = w_accept || (r_state == REQ) || (r_state == WAIT);
   assign addr_err   = w_reject;
   assign resp_valid = r_respValid;
   assign resp_rdata = r_respRdata;
   assign mem_req    = r_memReq;
   assign mem_we     = r_memWe;
   assign mem_addr   = r_memAddr;
   assign mem_be     = r_memBe;
   assign mem_wdata  = r_memWdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// ---------------------------------------------------------------------------
// tb_mem_access_unit
//
// Directed bench for mem_access_unit. A transaction driver plays the pipeline
// and a simple memory (configurable grant and read-return delays) and reports
// what it saw; each test task compares those observations with hand-derived
// expectations.
// ---------------------------------------------------------------------------
module tb_mem_access_unit;
   import mem_access_unit_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_write = 1'b0;
   logic [2:0]  req_type = 3'b000;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        mem_gnt = 1'b0;
   logic        mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = 32'h0;
   logic        stall;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        addr_err;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;

   int checks = 0;
   int errors = 0;

   // Observations returned by the transaction driver.
   int          stC, rpC, erC, rqC;
   logic [31:0] rd, sAddr, sWd;
   logic [3:0]  sBe;
   logic        sWe, stable, fin;

   mem_access_unit dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_write  (req_write),
      .req_type   (req_type),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .stall      (stall),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .addr_err   (addr_err),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_be     (mem_be),
      .mem_wdata  (mem_wdata),
      .mem_gnt    (mem_gnt),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata)
   );

   always #5 clk = ~clk;

   // Drives one request and emulates memory. Inputs change 1ns after the
   // rising edge, observations are taken on the falling edge. The request is
   // dropped after the first unstalled cycle, then three tail cycles are
   // watched for stray responses or requests. Bounded at 60 cycles.
   task automatic applyStimulus(input logic isWrite, input logic [2:0] typ,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input int gntDelay, input int rvDelay,
                                input logic [31:0] rword);
      int  rvCount;
      bit  granted;
      bit  doneSeen;
      int  tail;
      stC = 0; rpC = 0; erC = 0; rqC = 0;
      rd = 32'h0; sAddr = 32'h0; sWd = 32'h0; sBe = 4'h0; sWe = 1'b0;
      stable = 1'b1; fin = 1'b0;
      rvCount = 0; granted = 0; doneSeen = 0; tail = 0;
      @(posedge clk); #1;
      req_valid = 1'b1; req_write = isWrite; req_type = typ;
      req_addr = addr; req_wdata = wdata; mem_rdata = rword;
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      for (int cyc = 0; cyc < 60; cyc++) begin
         @(negedge clk);
         mem_gnt = 1'b0;
         mem_rvalid = 1'b0;
         if (stall) stC++;
         if (resp_valid) begin rpC++; rd = resp_rdata; end
         if (addr_err) erC++;
         if (mem_req) begin
            rqC++;
            if (rqC == 1) begin
               sAddr = mem_addr; sBe = mem_be; sWd = mem_wdata; sWe = mem_we;
            end else if (mem_addr !== sAddr || mem_be !== sBe ||
                         mem_wdata !== sWd || mem_we !== sWe) begin
               stable = 1'b0;
            end
            if (rqC > gntDelay && !granted) begin
               mem_gnt = 1'b1;
               granted = 1;
               rvCount = isWrite ? 0 : rvDelay;
            end
         end else if (granted && rvCount > 0) begin
            rvCount--;
            if (rvCount == 0) mem_rvalid = 1'b1;
         end
         if (doneSeen) begin
            tail++;
            if (tail >= 3) break;
         end else if (!stall) begin
            doneSeen = 1;
            fin = 1'b1;
         end
         @(posedge clk); #1;
         if (doneSeen) req_valid = 1'b0;
      end
      mem_gnt = 1'b0;
      mem_rvalid = 1'b0;
      req_valid = 1'b0;
   endtask

   task automatic test_reset();
      logic [104:0] obs;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      obs = {stall, resp_valid, resp_rdata, addr_err, mem_req, mem_we,
             mem_addr, mem_be, mem_wdata};
      checks++;
      if (obs !== '0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: got %h expected 0", obs);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   // Stores: SW, SB, SH, all granted immediately. Stall covers the accept and
   // REQ cycles only, and no response pulse is produced.
   task automatic test_stores();
      logic [31:0] addrs [3];
      logic [31:0] wds   [3];
      logic [2:0]  typs  [3];
      logic [3:0]  expBe [3];
      logic [31:0] expWd [3];
      addrs = '{32'h10, 32'h13, 32'h12};
      wds   = '{32'hDEADBEEF, 32'h000000A5, 32'h00001234};
      typs  = '{DT_WORD, DT_BYTEU, DT_HALFU};
      expBe = '{4'b1111, 4'b1000, 4'b1100};
      expWd = '{32'hDEADBEEF, 32'hA5A5A5A5, 32'h12341234};
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, typs[i], addrs[i], wds[i], 0, 1, 32'h0);
         checks++;
         if (fin !== 1'b1) begin errors++; $display("[TB] FAIL store%0d_done: got %b expected 1", i, fin); end
         checks++;
         if (sAddr !== 32'h10) begin errors++; $display("[TB] FAIL store%0d_addr: got %h expected 00000010", i, sAddr); end
         checks++;
         if (sBe !== expBe[i]) begin errors++; $display("[TB] FAIL store%0d_be: got %b expected %b", i, sBe, expBe[i]); end
         checks++;
         if (sWd !== expWd[i]) begin errors++; $display("[TB] FAIL store%0d_wdata: got %h expected %h", i, sWd, expWd[i]); end
         checks++;
         if (sWe !== 1'b1) begin errors++; $display("[TB] FAIL store%0d_we: got %b expected 1", i, sWe); end
         checks++;
         if (stC != 2) begin errors++; $display("[TB] FAIL store%0d_stall: got %0d expected 2", i, stC); end
         checks++;
         if (rpC != 0) begin errors++; $display("[TB] FAIL store%0d_resp: got %0d expected 0", i, rpC); end
      end
   endtask

   // Loads from word 0x80FF7F01 with read data returning 3 cycles after the
   // grant: stall = accept + REQ + 3 WAIT cycles = 5.
   task automatic test_loads();
      logic [31:0] addrs  [4];
      logic [2:0]  typs   [4];
      logic [3:0]  expBe  [4];
      logic [31:0] expRd  [4];
      addrs = '{32'h23, 32'h23, 32'h22, 32'h20};
      typs  = '{DT_BYTE, DT_BYTEU, DT_HALF, DT_HALFU};
      expBe = '{4'b1000, 4'b1000, 4'b1100, 4'b0011};
      expRd = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h00007F01};
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, typs[i], addrs[i], 32'h0, 0, 3, 32'h80FF7F01);
         checks++;
         if (fin !== 1'b1) begin errors++; $display("[TB] FAIL load%0d_done: got %b expected 1", i, fin); end
         checks++;
         if (rd !== expRd[i]) begin errors++; $display("[TB] FAIL load%0d_rdata: got %h expected %h", i, rd, expRd[i]); end
         checks++;
         if (rpC != 1) begin errors++; $display("[TB] FAIL load%0d_resp: got %0d expected 1", i, rpC); end
         checks++;
         if (stC != 5) begin errors++; $display("[TB] FAIL load%0d_stall: got %0d expected 5", i, stC); end
         checks++;
         if (sBe !== expBe[i] || sWe !== 1'b0 || sAddr !== 32'h20) begin
            errors++;
            $display("[TB] FAIL load%0d_port: got be=%b we=%b addr=%h expected be=%b we=0 addr=00000020",
                     i, sBe, sWe, sAddr, expBe[i]);
         end
      end
   endtask

   // Illegal accesses: misaligned LW, misaligned SH, unknown type, signed
   // code on a store. Each gives one addr_err pulse and no memory activity.
   task automatic test_errors();
      logic        wrs   [4];
      logic [2:0]  typs  [4];
      logic [31:0] addrs [4];
      wrs   = '{1'b0, 1'b1, 1'b0, 1'b1};
      typs  = '{DT_WORD, DT_HALFU, 3'b110, DT_BYTE};
      addrs = '{32'h102, 32'h101, 32'h100, 32'h100};
      for (int i = 0; i < 4; i++) begin
         applyStimulus(wrs[i], typs[i], addrs[i], 32'h55, 0, 1, 32'h0);
         checks++;
         if (erC != 1) begin errors++; $display("[TB] FAIL err%0d_pulse: got %0d expected 1", i, erC); end
         checks++;
         if (stC != 0) begin errors++; $display("[TB] FAIL err%0d_stall: got %0d expected 0", i, stC); end
         checks++;
         if (rqC != 0 || rpC != 0) begin
            errors++;
            $display("[TB] FAIL err%0d_nomem: got req=%0d resp=%0d expected 0 0", i, rqC, rpC);
         end
      end
   endtask

   // Grant withheld 4 cycles: mem_req held 5 cycles with a stable payload,
   // stall = accept + 5 REQ cycles = 6.
   task automatic test_gnt_withheld();
      applyStimulus(1'b1, DT_WORD, 32'h40, 32'h11223344, 4, 1, 32'h0);
      checks++;
      if (fin !== 1'b1) begin errors++; $display("[TB] FAIL gnt_done: got %b expected 1", fin); end
      checks++;
      if (rqC != 5) begin errors++; $display("[TB] FAIL gnt_reqcycles: got %0d expected 5", rqC); end
      checks++;
      if (stable !== 1'b1) begin errors++; $display("[TB] FAIL gnt_stable: got %b expected 1", stable); end
      checks++;
      if (stC != 6) begin errors++; $display("[TB] FAIL gnt_stall: got %0d expected 6", stC); end
      checks++;
      if (sAddr !== 32'h40 || sBe !== 4'hF || sWd !== 32'h11223344) begin
         errors++;
         $display("[TB] FAIL gnt_payload: got addr=%h be=%b wd=%h expected 00000040 1111 11223344", sAddr, sBe, sWd);
      end
   endtask

   // Load then store back to back; resp_rdata must keep the load result
   // across the store.
   task automatic test_back_to_back();
      applyStimulus(1'b0, DT_WORD, 32'h30, 32'h0, 0, 1, 32'hCAFEF00D);
      checks++;
      if (rd !== 32'hCAFEF00D) begin errors++; $display("[TB] FAIL b2b_lw_rdata: got %h expected cafef00d", rd); end
      checks++;
      if (stC != 3) begin errors++; $display("[TB] FAIL b2b_lw_stall: got %0d expected 3", stC); end
      applyStimulus(1'b1, DT_BYTEU, 32'h31, 32'h0000005A, 0, 1, 32'h0);
      checks++;
      if (sBe !== 4'b0010 || sWd !== 32'h5A5A5A5A) begin
         errors++;
         $display("[TB] FAIL b2b_sb_lanes: got be=%b wd=%h expected 0010 5a5a5a5a", sBe, sWd);
      end
      @(negedge clk);
      checks++;
      if (resp_rdata !== 32'hCAFEF00D) begin
         errors++;
         $display("[TB] FAIL b2b_hold: got %h expected cafef00d", resp_rdata);
      end
   endtask

   // Reset while a load waits for data, then a stray read return.
   task automatic test_reset_midflight();
      logic [104:0] obs;
      @(posedge clk); #1;
      req_valid = 1'b1; req_write = 1'b0; req_type = DT_WORD;
      req_addr = 32'h50; mem_rdata = 32'h13579BDF;
      @(negedge clk);
      @(posedge clk); #1;
      @(negedge clk);
      mem_gnt = 1'b1;
      @(posedge clk); #1;
      mem_gnt = 1'b0;
      @(negedge clk);
      checks++;
      if (stall !== 1'b1 || mem_req !== 1'b0) begin
         errors++;
         $display("[TB] FAIL rstmid_inwait: got stall=%b req=%b expected 1 0", stall, mem_req);
      end
      @(posedge clk); #1;
      rst_n = 1'b0; req_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1; mem_rvalid = 1'b1;
      @(negedge clk);
      obs = {stall, resp_valid, resp_rdata, addr_err, mem_req, mem_we,
             mem_addr, mem_be, mem_wdata};
      checks++;
      if (obs !== '0) begin errors++; $display("[TB] FAIL rstmid_outputs: got %h expected 0", obs); end
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b0 || stall !== 1'b0 || mem_req !== 1'b0) begin
         errors++;
         $display("[TB] FAIL rstmid_stray: got resp=%b stall=%b req=%b expected 0 0 0", resp_valid, stall, mem_req);
      end
      applyStimulus(1'b0, DT_WORD, 32'h50, 32'h0, 0, 1, 32'h0BADF00D);
      checks++;
      if (fin !== 1'b1 || rpC != 1) begin
         errors++;
         $display("[TB] FAIL rstmid_after_done: got fin=%b resp=%0d expected 1 1", fin, rpC);
      end
      checks++;
      if (rd !== 32'h0BADF00D) begin errors++; $display("[TB] FAIL rstmid_after_rdata: got %h expected 0badf00d", rd); end
   endtask

   // Test sequence.
   initial begin
      test_reset();
      test_stores();
      test_loads();
      test_errors();
      test_gnt_withheld();
      test_back_to_back();
      test_reset_midflight();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage responder for the load/store control the decoder produces (store enable, access-type code, address, store data). Turns each load/store into at most one transaction on a word-wide, variable-latency data-memory port. Stalls the pipeline until the transaction completes and returns sign- or zero-extended load data. Sits between the MEM pipeline register and the data memory/bus.

## Interface
Parameters: none. Fixed 32-bit data and address, little-endian byte order.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset: synchronous, active-low.
- req_valid  in  1  MEM stage holds a load or store.
- req_write  in  1  1 = store, 0 = load.
- req_type  in  3  access-type code:
  - 000 word
  - 010 half unsigned / SH
  - 011 half signed
  - 100 byte unsigned / SB
  - 101 byte signed
- req_addr  in  32  effective byte address.
- req_wdata  in  32  store data; meaningful bits are low-aligned.
- stall  out  1  pipeline must hold MEM-stage inputs stable.
- resp_valid  out  1  one-cycle pulse; resp_rdata valid (loads only).
- resp_rdata  out  32  extended load result.
- addr_err  out  1  one-cycle pulse on misaligned address or illegal type.
- mem_req  out  1  memory request.
- mem_we  out  1  write request.
- mem_addr  out  32  word address, {req_addr[31:2],2'b00}.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-replicated store data.
- mem_gnt  in  1  request accepted this cycle.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  32  read word.

## Operation
- FSM states:
  - IDLE: no request in flight.
  - REQ: mem_req high, waiting for mem_gnt.
  - WAIT: load granted, waiting for mem_rvalid.
  - DONE: completion cycle.
- IDLE, req_valid=1, access legal: latch write, type, addr, wdata; stall=1; go to REQ.
- IDLE, req_valid=1, access illegal: addr_err=1 and stall=0 that cycle; no memory access; stay IDLE.
- Illegal access is any of:
  - type not in {000,010,011,100,101};
  - req_write with type 011 or 101;
  - word access with addr[1:0]≠0;
  - half access with addr[0]≠0.
- REQ: mem_req=1; mem_we/addr/be/wdata come from the latch and are held stable until mem_gnt. On mem_gnt: store → DONE, load → WAIT.
- WAIT: on mem_rvalid, capture the extended data into resp_rdata and go to DONE.
- DONE: stall=0, resp_valid=1 for loads (0 for stores), then IDLE.
- Byte enables:
  - word: 1111
  - half: 0011 if addr[1]=0, else 1100
  - byte: 1 << addr[1:0]
- Store data: byte replicated into all 4 lanes; half replicated into both halves; word passed through.
- Load extension:
  - byte lane = addr[1:0]; half lane = addr[1];
  - types 011 and 101 sign-extend, 010 and 100 zero-extend.
- resp_rdata holds its value until the next load completes.
- mem_rvalid outside WAIT is ignored. mem_gnt outside REQ is ignored.

## Timing
- Reset: state=IDLE and every output 0 (stall, resp_valid, resp_rdata, addr_err, mem_req, mem_we, mem_addr, mem_be, mem_wdata).
- Reset mid-transaction aborts it with no resp_valid. A late mem_rvalid after reset is ignored.
- stall is combinational: (IDLE & req_valid & legal) | REQ | WAIT.
- mem_req is registered; it first rises the cycle after acceptance.
- Minimum latency, counting the acceptance cycle as 0:
  - store: 0 accept, 1 REQ+gnt, 2 DONE → 3 cycles, 2 stalled.
  - load (gnt immediate, rvalid next cycle): 0, 1 REQ+gnt, 2 WAIT+rvalid, 3 DONE.
- The pipeline advances at the end of DONE. The next request is seen in IDLE the following cycle, so there are no back-to-back duplicates.
- mem_rvalid may arrive no earlier than the cycle after mem_gnt.
- One outstanding transaction maximum.

## Structure
- Shared package holds:
  - access-type codes: DT_WORD=000, DT_HALFU=010, DT_HALF=011, DT_BYTEU=100, DT_BYTE=101;
  - FSM state encodings: IDLE/REQ/WAIT/DONE.
- The decoder uses the same type codes.
- One combinational sub-module, mem_load_ext: inputs rdata, addr[1:0], type; output extended word. Reusable by the simulator model.
- Lane and byte-enable generation stays in mem_access_unit.

## Test plan
- Store SW addr 0x0000_0010, wdata 0xDEADBEEF, gnt immediate → mem_addr 0x10, be 1111, wdata 0xDEADBEEF; stall high 2 cycles; no resp_valid.
- SB addr 0x13, wdata 0x0000_00A5 → be 1000, mem_wdata 0xA5A5A5A5. SH addr 0x12, wdata 0x1234 → be 1100, mem_wdata 0x12341234.
- Load byte from word 0x80FF_7F01 with rvalid delayed 3 cycles:
  - LB addr 0x…3 → 0xFFFFFF80;
  - LBU addr 0x…3 → 0x00000080;
  - LH addr 0x…2 → 0xFFFF80FF;
  - LHU addr 0x…0 → 0x00007F01.
  Stall spans the whole wait; resp_valid is a single pulse.
- Check each error case → addr_err pulse, stall 0, mem_req never rises:
  - LW addr 0x…2;
  - SH addr 0x…1;
  - type 110;
  - store with type 101.
- mem_gnt withheld 4 cycles → mem_req, mem_addr, mem_be, mem_wdata stable throughout; completes on the 5th cycle.
- Reset asserted in WAIT, then a stray mem_rvalid → all outputs 0, state IDLE, no resp_valid. A following legal LW completes normally.
